// File: rtl/fifo_drain_arbiter_pkg.sv
// Shared types and helpers for the FIFO drain arbiter.
// Holds the scheduler state encoding, the out_src width and a constant-safe clog2.
package fifo_drain_arbiter_pkg;

    localparam int unsigned SRC_IDX_W = 3;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } arb_state_e;

    // Smallest r with 2**r >= value; usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first set request bit at ptr, ptr+1, ... wrapping at N_REQ.
// Wrap is an explicit compare so non-power-of-two source counts behave correctly.
module fifo_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // One extra bit so ptr + k (both < N_REQ) never overflows before the wrap.
    logic [IDX_W:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!found_o && req_i[cand[IDX_W-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Read-side scheduler sharing one sink among N_SRC FIFOs: round-robin grants of up to
// BURST_MAX words, combinational RD strobes and a registered valid/ready output stage.
module fifo_drain_arbiter
    import fifo_drain_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N_SRC      = 4,
    parameter int unsigned BURST_MAX  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en_i,
    input  logic                        flush_i,
    input  logic [N_SRC-1:0]            fifo_empty_i,
    input  logic [N_SRC*DATA_WIDTH-1:0] fifo_q_i,
    output logic [N_SRC-1:0]            fifo_rd_o,
    output logic [DATA_WIDTH-1:0]       out_data_o,
    output logic [SRC_IDX_W-1:0]        out_src_o,
    output logic                        out_last_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic                        busy_o
);

    localparam int unsigned PtrW = clog2(N_SRC);
    localparam int unsigned CntW = clog2(BURST_MAX) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(BURST_MAX - 1);
    localparam logic [PtrW-1:0] LastSrc = PtrW'(N_SRC - 1);

    arb_state_e            state_q, state_d;
    logic [PtrW-1:0]       ptr_q, ptr_d;
    logic [PtrW-1:0]       grant_q, grant_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [PtrW-1:0]       out_src_q, out_src_d;
    logic                  out_last_q, out_last_d;
    logic                  out_valid_q, out_valid_d;

    logic [N_SRC-1:0]      req;
    logic                  pick_found;
    logic [PtrW-1:0]       pick_idx;
    logic                  grant_empty;
    logic [DATA_WIDTH-1:0] grant_word;
    logic                  sink_free;
    logic                  take;
    logic                  burst_full;
    logic [PtrW-1:0]       ptr_after;

    assign req = ~fifo_empty_i;

    fifo_rr_pick #(
        .N_REQ (N_SRC),
        .IDX_W (PtrW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign grant_empty = fifo_empty_i[grant_q];
    assign grant_word  = fifo_q_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign sink_free   = ~out_valid_q | out_ready_i;
    // Flush masks the pop so a word is never consumed in a cycle that discards it.
    assign take        = (state_q == StBurst) & en_i & ~grant_empty & sink_free & ~flush_i;
    assign burst_full  = (cnt_q == LastCnt);
    assign ptr_after   = (grant_q == LastSrc) ? '0 : grant_q + 1'b1;

    always_comb begin
        fifo_rd_o = '0;
        if (take) begin
            fifo_rd_o[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (flush_i) begin
            state_d     = StIdle;
            ptr_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            if (take) begin
                out_data_d  = grant_word;
                out_src_d   = grant_q;
                out_last_d  = burst_full;
                out_valid_d = 1'b1;
            end else if (out_ready_i) begin
                out_valid_d = 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (en_i && pick_found) begin
                        grant_d = pick_idx;
                        cnt_d   = '0;
                        state_d = StBurst;
                    end
                end
                StBurst: begin
                    if (take) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // The granted source drops to lowest priority however the burst ends.
                    if ((take && burst_full) || grant_empty || !en_i) begin
                        state_d = StIdle;
                        ptr_d   = ptr_after;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_src_o   = SRC_IDX_W'(out_src_q);
    assign out_last_o  = out_last_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = (state_q != StIdle) | out_valid_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: queue-backed FIFO models, a cycle reference model of the
// scheduling rules, directed scenarios followed by randomized traffic.
module tb_fifo_drain_arbiter;

    localparam int N  = 4;
    localparam int BM = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en, flush, ready;
    logic [N-1:0]    fifo_empty, fifo_rd;
    logic [N*DW-1:0] fifo_q;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_src;
    logic            out_last, out_valid, busy;

    always #5 clk = ~clk;

    fifo_drain_arbiter #(
        .DATA_WIDTH (DW),
        .N_SRC      (N),
        .BURST_MAX  (BM)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .flush_i      (flush),
        .fifo_empty_i (fifo_empty),
        .fifo_q_i     (fifo_q),
        .fifo_rd_o    (fifo_rd),
        .out_data_o   (out_data),
        .out_src_o    (out_src),
        .out_last_o   (out_last),
        .out_valid_o  (out_valid),
        .out_ready_i  (ready),
        .busy_o       (busy)
    );

    typedef logic [7:0] word_q_t[$];
    word_q_t fq [N];
    int      push_seq [N];

    // Reference model of the scheduling rules.
    bit       m_burst, m_ov, m_ol;
    int       m_ptr, m_grant, m_cnt, m_os;
    logic [7:0] m_od;

    int n_tests = 0;
    int n_fail  = 0;
    int rd_count [N];
    int last_count;
    int acc_src[$];
    int acc_data[$];
    int acc_last[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] w;
            w = {3'(s), 5'(push_seq[s])};
            fq[s].push_back(w);
            push_seq[s]++;
        end
    endtask

    task automatic drive_fifo();
        for (int i = 0; i < N; i++) begin
            fifo_empty[i]       = (fq[i].size() == 0);
            fifo_q[i*DW +: DW]  = (fq[i].size() != 0) ? fq[i][0] : 8'h00;
        end
    endtask

    task automatic model_reset();
        m_burst = 0; m_ptr = 0; m_grant = 0; m_cnt = 0;
        m_ov = 0; m_ol = 0; m_od = 8'h00; m_os = 0;
    endtask

    task automatic clear_acc();
        acc_src.delete(); acc_data.delete(); acc_last.delete();
        last_count = 0;
        for (int i = 0; i < N; i++) rd_count[i] = 0;
    endtask

    // One clock: check outputs at the falling edge, advance model, pop FIFOs after the edge.
    task automatic cycle();
        bit         take, ended, full;
        int         exp_rd, c;
        logic [N-1:0] rd_snap;
        drive_fifo();
        @(negedge clk);
        take   = m_burst && en && (fq[m_grant].size() > 0) && (!m_ov || ready) && !flush;
        exp_rd = take ? (1 << m_grant) : 0;
        chk("fifo_rd", 32'(fifo_rd), 32'(exp_rd));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_data", 32'(out_data), 32'(m_od));
            chk("out_src", 32'(out_src), 32'(m_os));
            chk("out_last", 32'(out_last), 32'(m_ol));
        end
        chk("busy", 32'(busy), 32'(m_burst || m_ov));
        if (out_valid && ready) begin
            acc_src.push_back(int'(out_src));
            acc_data.push_back(int'(out_data));
            acc_last.push_back(int'(out_last));
            if (out_last) last_count++;
        end
        rd_snap = fifo_rd;
        for (int i = 0; i < N; i++) if (rd_snap[i]) rd_count[i]++;

        if (flush) begin
            m_burst = 0; m_ptr = 0; m_cnt = 0; m_ov = 0; m_ol = 0;
        end else begin
            full = (m_cnt == BM - 1);
            if (take) begin
                m_od = fq[m_grant][0]; m_os = m_grant; m_ol = full; m_ov = 1;
            end else if (ready) begin
                m_ov = 0;
            end
            if (!m_burst) begin
                if (en) begin
                    for (int k = 0; k < N; k++) begin
                        c = (m_ptr + k) % N;
                        if (!m_burst && fq[c].size() > 0) begin
                            m_grant = c; m_cnt = 0; m_burst = 1;
                        end
                    end
                end
            end else begin
                ended = (take && full) || (fq[m_grant].size() == 0) || !en;
                if (take) m_cnt++;
                if (ended) begin
                    m_burst = 0;
                    m_ptr   = (m_grant + 1) % N;
                end
            end
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rd_snap[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_flush();
        flush = 1;
        cycle();
        flush = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int rr_exp [13] = '{0, 0, 0, 0, 2, 2, 2, 2, 3, 3, 3, 3, 0};
        int s0;
        for (int i = 0; i < N; i++) push_seq[i] = 0;
        rst_n = 0; en = 0; flush = 0; ready = 1;
        model_reset();
        clear_acc();
        drive_fifo();
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_rd", 32'(fifo_rd), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_src", 32'(out_src), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #20;
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;

        // Single source, burst split 4 + 2.
        en = 1;
        push(1, 6);
        clear_acc();
        run(14);
        chk("single_rd_count", 32'(rd_count[1]), 32'd6);
        chk("single_words", 32'(acc_src.size()), 32'd6);
        chk("single_last_count", 32'(last_count), 32'd1);
        if (acc_last.size() == 6) begin
            chk("single_last_a3", 32'(acc_last[3]), 32'd1);
            chk("single_src", 32'(acc_src[5]), 32'd1);
        end

        // Round-robin across 0, 2, 3.
        do_flush();
        push(0, 8); push(2, 8); push(3, 8);
        clear_acc();
        run(40);
        chk("rr_words", 32'(acc_src.size()), 32'd24);
        for (int i = 0; i < 13; i++) begin
            chk("rr_order", 32'((i < acc_src.size()) ? acc_src[i] : -1), 32'(rr_exp[i]));
        end

        // Backpressure: hold word0 for 5 cycles.
        do_flush();
        s0 = push_seq[0];
        push(0, 4);
        clear_acc();
        for (int k = 0; k < 10 && !out_valid; k++) cycle();
        chk("bp_wait_valid", 32'(out_valid), 32'd1);
        ready = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_hold_data", 32'(out_data), 32'({3'd0, 5'(s0)}));
        end
        ready = 1;
        run(8);
        chk("bp_words", 32'(acc_data.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("bp_order", 32'((i < acc_data.size()) ? acc_data[i] : -1),
                32'({3'd0, 5'(s0 + i)}));
        end

        // Flush on the second read of a burst.
        do_flush();
        push(0, 4);
        cycle();
        cycle();
        flush = 1;
        cycle();
        flush = 0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_left", 32'(fq[0].size()), 32'd3);
        push(1, 2);
        clear_acc();
        run(12);
        chk("flush_regrant", 32'((acc_src.size() > 0) ? acc_src[0] : -1), 32'd0);

        // Early empty: 2 words, no out_last, next search from 3.
        do_flush();
        push(2, 2);
        clear_acc();
        run(6);
        chk("early_words", 32'(acc_src.size()), 32'd2);
        chk("early_no_last", 32'(last_count), 32'd0);
        chk("early_idle", 32'(busy), 32'd0);
        push(1, 2); push(3, 2);
        clear_acc();
        run(10);
        chk("early_next", 32'((acc_src.size() > 0) ? acc_src[0] : -1), 32'd3);

        // Randomized traffic.
        for (int t = 0; t < 400; t++) begin
            en    = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 49) == 0);
            ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 2) == 0) push(int'($urandom_range(0, N - 1)), 1);
            cycle();
        end
        en = 1; flush = 0; ready = 1;
        run(60);

        // Asynchronous reset while a word is held.
        do_flush();
        push(0, 3);
        ready = 0;
        for (int k = 0; k < 10 && !out_valid; k++) cycle();
        chk("arst_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_src", 32'(out_src), 32'd0);
        chk("arst_last", 32'(out_last), 32'd0);
        chk("arst_rd", 32'(fifo_rd), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        model_reset();
        en = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        en = 1; ready = 1;
        run(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
